simon_host_if: RTL and testbench
================================

Name: simon_host_if

Overview:
- Host-side initiator for the SIMON_128192 cipher core handshake (newKey/ldKey/doneKey, newData/ldData/doneData/readData).
- Accepts keys and blocks from upstream valid/ready streams and drives the core's four-phase request/acknowledge protocol.
- Collects each cipher result and presents it on a downstream valid/ready stream.
- Sits between the system datapath and the cipher core; replaces the bench-driven handshake in synthesised designs.

Parameters:
- N, 64, word width; a block is 2*N bits.
- M, 3, key words; the key is M*N bits.
- TO, 255, watchdog limit in cycles for any wait on the core (8-bit counter, 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- nR  in  1  asynchronous active-low reset.
- key_valid  in  1  upstream key offered.
- key_in  in  M*N  key, word 0 in the LSBs.
- key_ready  out  1  key accepted when key_valid & key_ready.
- blk_valid  in  1  upstream block offered.
- blk_in  in  2N  plaintext or ciphertext.
- blk_mode  in  1  1 = encrypt, 0 = decrypt.
- blk_ready  out  1  block accepted when blk_valid & blk_ready.
- res_valid  out  1  result available.
- res_data  out  2N  result block.
- res_mode  out  1  mode used for this result.
- res_ready  in  1  downstream accepts the result.
- err  out  1  sticky watchdog error.
- err_clr  in  1  single-cycle pulse that clears err.
- newKey, newData, enc_dec, readData  out  1 each  core requests.
- key  out  M*N  core key bus.
- plain  out  2N  core data bus.
- ldKey, ldData, doneKey, doneData  in  1 each  core acknowledges; synchronous to clk.
- cipher  in  2N  core result bus.

Behaviour:
- Reset (nR low, asynchronous): state IDLE; all outputs 0 (key, plain, res_data, res_mode, err included); key_loaded flag 0; watchdog counter 0.
- Registered outputs: key_ready = (state==IDLE) & ~err. blk_ready = (state==IDLE) & key_loaded & ~key_valid & ~err, so a pending key has priority over a block.
- IDLE:
  - On a key handshake: latch key_in into key, clear key_loaded, go KEY_REQ; newKey rises on the next edge.
  - Otherwise, on a block handshake: latch blk_in into plain and blk_mode into enc_dec, go DATA_REQ; newData rises on the next edge.
- KEY_REQ: hold newKey=1. When ldKey=1 is sampled, drop newKey and go KEY_REL.
- KEY_REL: wait for ldKey=0, then go KEY_WAIT.
- KEY_WAIT: wait for doneKey=1, then set key_loaded and go IDLE.
- DATA_REQ: hold newData=1; plain and enc_dec stay stable. When ldData=1 is sampled, drop newData and go DATA_REL.
- DATA_REL: wait for ldData=0, then go RUN.
- RUN: wait for doneData=1. Capture cipher into res_data and enc_dec into res_mode, assert readData, go READ.
- READ: hold readData until doneData=0 is sampled, then drop readData, set res_valid, go OUT.
- OUT: hold res_valid, res_data and res_mode until res_ready=1. The handshake cycle clears res_valid; go IDLE. Minimum accept-to-next-accept spacing is therefore the core latency plus 6 cycles.
- key, plain and enc_dec are never changed outside IDLE.
- Watchdog:
  - The counter resets on every state change and increments in each of KEY_REQ, KEY_REL, KEY_WAIT, DATA_REQ, DATA_REL, RUN and READ.
  - When it reaches TO: set err, drop all core requests and readData, clear key_loaded, go IDLE.
  - OUT has no timeout; downstream may stall indefinitely.
- err is sticky. It blocks key_ready and blk_ready until an err_clr pulse. An err_clr on the same cycle as a timeout leaves err set.
- Simultaneous key_valid and blk_valid in IDLE: the key is taken and the block waits.
- A new key can only be loaded in IDLE, i.e. never while a block is in flight or a result is held.
- Reset mid-operation: all requests drop asynchronously and any held result is discarded. The core shares nR and resets with this block.

Decomposition:
- Shared package simon_pkg holds N, M, TO defaults and the typedefs block_t (logic [2N-1:0]), key_t (logic [M-1:0][N-1:0]) and host_state_e.
- One sub-module, simon_wdog, holds the 8-bit watchdog: inputs clk, nR, run, restart; output expired.
- Everything else lives in one always_ff FSM with a registered-output block.

Test Plan:
- Key 192'h17161514131211100F0E0D0C0B0A09080706050403020100, then block 128'h206572656874206E6568772065626972 with blk_mode=1, against a real SIMON_128192 -> res_data=128'hC4AC61EFFCDC0D4F6C9C8D6E2597B85B, res_mode=1, exactly one res_valid handshake.
- Feed that cipher back with blk_mode=0 -> res_data=128'h206572656874206E6568772065626972, res_mode=0.
- blk_valid=1 after reset with no key loaded -> blk_ready stays 0 for 20 cycles. Then offer key and block together -> key is taken first, block taken only after doneKey.
- Hold res_ready=0 for 50 cycles -> res_valid, res_data and res_mode stable, blk_ready=0, no newData. Then res_ready=1 -> one handshake and blk_ready returns.
- Stub core that never asserts ldData, TO=16 -> newData held exactly 16 cycles, then err=1, newData=0, key_ready=0. err_clr pulse -> err=0, key_ready=1, blk_ready=0 until a key is reloaded.
- nR low for 1 cycle while in RUN -> all outputs 0 immediately, res_valid never asserts, key_loaded=0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared defaults, data types and state encoding for the SIMON host-side handshake.
package simon_pkg;
    localparam int N_DEF  = 64;
    localparam int M_DEF  = 3;
    localparam int TO_DEF = 255;

    typedef logic [2*N_DEF-1:0]          block_t;
    typedef logic [M_DEF-1:0][N_DEF-1:0] key_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KEY_REQ,
        S_KEY_REL,
        S_KEY_WAIT,
        S_DATA_REQ,
        S_DATA_REL,
        S_RUN,
        S_READ,
        S_OUT
    } host_state_e;

    // States in which the block is waiting on the core and the watchdog runs.
    function automatic logic is_core_wait(input host_state_e s);
        return (s != S_IDLE) && (s != S_OUT);
    endfunction
endpackage

// File: rtl/simon_wdog.sv
// Watchdog for waits on the cipher core: counts cycles spent in the current
// wait state and flags expiry on the cycle that would make the count reach TO.
module simon_wdog #(
    parameter int TO = simon_pkg::TO_DEF
) (
    input  logic clk,
    input  logic nR,
    input  logic run,
    input  logic restart,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TO - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !run) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed cycles in this state; this cycle is number cnt_q+1.
    assign expired = run && (cnt_q == LIMIT);
endmodule

// File: rtl/simon_host_if.sv
// Host-side initiator for the SIMON_128192 core: takes keys and blocks from
// valid/ready streams, sequences the core's four-phase handshake, returns results.
module simon_host_if
    import simon_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int M  = M_DEF,
    parameter int TO = TO_DEF
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             key_valid,
    input  logic [M*N-1:0]   key_in,
    output logic             key_ready,
    input  logic             blk_valid,
    input  logic [2*N-1:0]   blk_in,
    input  logic             blk_mode,
    output logic             blk_ready,
    output logic             res_valid,
    output logic [2*N-1:0]   res_data,
    output logic             res_mode,
    input  logic             res_ready,
    output logic             err,
    input  logic             err_clr,
    output logic             newKey,
    output logic             newData,
    output logic             enc_dec,
    output logic             readData,
    output logic [M*N-1:0]   key,
    output logic [2*N-1:0]   plain,
    input  logic             ldKey,
    input  logic             ldData,
    input  logic             doneKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   cipher
);
    host_state_e    state_q, state_d;
    logic [M*N-1:0] key_q, key_d;
    logic [2*N-1:0] plain_q, plain_d;
    logic [2*N-1:0] res_data_q, res_data_d;
    logic           enc_dec_q, enc_dec_d;
    logic           new_key_q, new_key_d;
    logic           new_data_q, new_data_d;
    logic           read_data_q, read_data_d;
    logic           res_valid_q, res_valid_d;
    logic           res_mode_q, res_mode_d;
    logic           err_q, err_d;
    logic           key_loaded_q, key_loaded_d;
    logic           key_ready_q, key_ready_d;
    logic           blk_ready_q, blk_ready_d;
    logic           wd_run, wd_restart, wd_expired;

    simon_wdog #(.TO(TO)) u_wdog (
        .clk     (clk),
        .nR      (nR),
        .run     (wd_run),
        .restart (wd_restart),
        .expired (wd_expired)
    );

    assign wd_run     = is_core_wait(state_q);
    assign wd_restart = (state_d != state_q);

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        plain_d      = plain_q;
        res_data_d   = res_data_q;
        enc_dec_d    = enc_dec_q;
        new_key_d    = new_key_q;
        new_data_d   = new_data_q;
        read_data_d  = read_data_q;
        res_valid_d  = res_valid_q;
        res_mode_d   = res_mode_q;
        err_d        = err_q;
        key_loaded_d = key_loaded_q;

        case (state_q)
            S_IDLE: begin
                // key_ready_q already implies IDLE and no error; keys win over blocks.
                if (key_valid && key_ready_q) begin
                    key_d        = key_in;
                    key_loaded_d = 1'b0;
                    new_key_d    = 1'b1;
                    state_d      = S_KEY_REQ;
                end else if (blk_valid && blk_ready_q) begin
                    plain_d    = blk_in;
                    enc_dec_d  = blk_mode;
                    new_data_d = 1'b1;
                    state_d    = S_DATA_REQ;
                end
            end
            S_KEY_REQ: if (ldKey) begin
                new_key_d = 1'b0;
                state_d   = S_KEY_REL;
            end
            S_KEY_REL: if (!ldKey) state_d = S_KEY_WAIT;
            S_KEY_WAIT: if (doneKey) begin
                key_loaded_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_DATA_REQ: if (ldData) begin
                new_data_d = 1'b0;
                state_d    = S_DATA_REL;
            end
            S_DATA_REL: if (!ldData) state_d = S_RUN;
            S_RUN: if (doneData) begin
                res_data_d  = cipher;
                res_mode_d  = enc_dec_q;
                read_data_d = 1'b1;
                state_d     = S_READ;
            end
            S_READ: if (!doneData) begin
                read_data_d = 1'b0;
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (err_clr) err_d = 1'b0;

        // A timeout overrides both the state step and a coincident err_clr.
        if (wd_expired) begin
            err_d        = 1'b1;
            new_key_d    = 1'b0;
            new_data_d   = 1'b0;
            read_data_d  = 1'b0;
            key_loaded_d = 1'b0;
            state_d      = S_IDLE;
        end

        key_ready_d = (state_d == S_IDLE) && !err_d;
        blk_ready_d = (state_d == S_IDLE) && key_loaded_d && !key_valid && !err_d;
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            plain_q      <= '0;
            res_data_q   <= '0;
            enc_dec_q    <= 1'b0;
            new_key_q    <= 1'b0;
            new_data_q   <= 1'b0;
            read_data_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_mode_q   <= 1'b0;
            err_q        <= 1'b0;
            key_loaded_q <= 1'b0;
            key_ready_q  <= 1'b0;
            blk_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            plain_q      <= plain_d;
            res_data_q   <= res_data_d;
            enc_dec_q    <= enc_dec_d;
            new_key_q    <= new_key_d;
            new_data_q   <= new_data_d;
            read_data_q  <= read_data_d;
            res_valid_q  <= res_valid_d;
            res_mode_q   <= res_mode_d;
            err_q        <= err_d;
            key_loaded_q <= key_loaded_d;
            key_ready_q  <= key_ready_d;
            blk_ready_q  <= blk_ready_d;
        end
    end

    assign key_ready = key_ready_q;
    assign blk_ready = blk_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_mode  = res_mode_q;
    assign err       = err_q;
    assign newKey    = new_key_q;
    assign newData   = new_data_q;
    assign enc_dec   = enc_dec_q;
    assign readData  = read_data_q;
    assign key       = key_q;
    assign plain     = plain_q;
endmodule

// File: tb/tb_simon_host_if.sv
// Bench for simon_host_if: a behavioural SIMON_128192 core stub answers the
// handshake, and a queue-based model predicts each result from the stream inputs.
module tb_simon_host_if;
    localparam int N  = 64;
    localparam int M  = 3;
    localparam int TO = 16;
    localparam int KW = M * N;
    localparam int BW = 2 * N;

    localparam logic [KW-1:0] KAT_KEY = 192'h17161514131211100F0E0D0C0B0A09080706050403020100;
    localparam logic [BW-1:0] KAT_PT  = 128'h206572656874206E6568772065626972;
    localparam logic [BW-1:0] KAT_CT  = 128'hC4AC61EFFCDC0D4F6C9C8D6E2597B85B;

    logic          clk = 1'b0;
    logic          nR = 1'b0;
    logic          key_valid = 1'b0;
    logic [KW-1:0] key_in = '0;
    logic          key_ready;
    logic          blk_valid = 1'b0;
    logic [BW-1:0] blk_in = '0;
    logic          blk_mode = 1'b0;
    logic          blk_ready;
    logic          res_valid;
    logic [BW-1:0] res_data;
    logic          res_mode;
    logic          res_ready = 1'b0;
    logic          err;
    logic          err_clr = 1'b0;
    logic          newKey, newData, enc_dec, readData;
    logic [KW-1:0] key;
    logic [BW-1:0] plain;
    logic          ldKey = 1'b0, ldData = 1'b0, doneKey = 1'b0, doneData = 1'b0;
    logic [BW-1:0] cipher = '0;

    always #5 clk = ~clk;

    simon_host_if #(.N(N), .M(M), .TO(TO)) dut (
        .clk(clk), .nR(nR),
        .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .blk_valid(blk_valid), .blk_in(blk_in), .blk_mode(blk_mode), .blk_ready(blk_ready),
        .res_valid(res_valid), .res_data(res_data), .res_mode(res_mode), .res_ready(res_ready),
        .err(err), .err_clr(err_clr),
        .newKey(newKey), .newData(newData), .enc_dec(enc_dec), .readData(readData),
        .key(key), .plain(plain),
        .ldKey(ldKey), .ldData(ldData), .doneKey(doneKey), .doneData(doneData),
        .cipher(cipher)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- SIMON_128192 reference ----------------
    function automatic logic [63:0] rol(input logic [63:0] x, input int s);
        return (x << s) | (x >> (64 - s));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int s);
        return (x >> s) | (x << (64 - s));
    endfunction

    function automatic logic [63:0] rf(input logic [63:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [BW-1:0] simon_model(input logic [KW-1:0] k, input logic [BW-1:0] b,
                                                  input logic enc);
        logic [63:0] rk [69];
        logic [63:0] x, y, t;
        logic [61:0] z3;
        z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
        rk[0] = k[63:0];
        rk[1] = k[127:64];
        rk[2] = k[191:128];
        for (int i = 3; i < 69; i++) begin
            t = ror(rk[i-1], 3) ^ ror(rk[i-1], 4);
            rk[i] = 64'hFFFF_FFFF_FFFF_FFFC ^ {63'd0, z3[(i-3) % 62]} ^ rk[i-3] ^ t;
        end
        x = b[127:64];
        y = b[63:0];
        if (enc) begin
            for (int i = 0; i < 69; i++) begin
                t = x; x = y ^ rf(x) ^ rk[i]; y = t;
            end
        end else begin
            for (int i = 68; i >= 0; i--) begin
                t = y; y = x ^ rf(y) ^ rk[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    // ---------------- core stub ----------------
    int            cs = 0;
    int            dly = 0;
    int            stub_run_dly = -1;
    bit            stub_no_ack = 1'b0;
    logic [KW-1:0] core_key = '0;
    logic [BW-1:0] core_plain = '0;
    logic          core_mode = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!nR) begin
                ldKey = 1'b0; ldData = 1'b0; doneKey = 1'b0; doneData = 1'b0; cs = 0;
            end else begin
                case (cs)
                    0: if (newKey) begin
                           dly = int'($urandom_range(0, 3)); cs = 1;
                       end else if (newData && !stub_no_ack) begin
                           dly = int'($urandom_range(0, 3)); cs = 5;
                       end
                    1: if (dly == 0) begin ldKey = 1'b1; core_key = key; cs = 2; end else dly--;
                    2: if (!newKey) begin ldKey = 1'b0; dly = int'($urandom_range(0, 5)); cs = 3; end
                    3: if (dly == 0) begin doneKey = 1'b1; cs = 4; end else dly--;
                    4: begin doneKey = 1'b0; cs = 0; end
                    5: if (dly == 0) begin
                           ldData = 1'b1; core_plain = plain; core_mode = enc_dec; cs = 6;
                       end else dly--;
                    6: if (!newData) begin
                           ldData = 1'b0;
                           if (stub_run_dly >= 0) dly = stub_run_dly;
                           else dly = int'($urandom_range(1, 10));
                           cs = 7;
                       end
                    7: if (dly == 0) begin
                           cipher = simon_model(core_key, core_plain, core_mode);
                           doneData = 1'b1; cs = 8;
                       end else dly--;
                    8: if (readData) begin doneData = 1'b0; cs = 9; end
                    9: if (!readData) begin
                           cipher = {$urandom, $urandom, $urandom, $urandom}; cs = 0;
                       end
                    default: cs = 0;
                endcase
            end
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int res_hs = 0;
    int key_hs_cyc = -1;
    int blk_hs_cyc = -1;
    int donekey_cyc = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (res_valid && res_ready) res_hs++;
        if (key_valid && key_ready) key_hs_cyc = cyc;
        if (blk_valid && blk_ready) blk_hs_cyc = cyc;
        if (doneKey) donekey_cyc = cyc;
    end

    // ---------------- drivers and model ----------------
    logic [KW-1:0] cur_key = '0;
    logic [BW:0]   exp_q[$];
    logic [BW-1:0] last_data;
    logic          last_mode;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_key(input logic [KW-1:0] k);
        int w = 0;
        key_in = k;
        key_valid = 1'b1;
        while (!key_ready && w < 200) begin tick(); w++; end
        check_eq("key_accept", key_ready, 1'b1);
        tick();
        key_valid = 1'b0;
        cur_key = k;
    endtask

    task automatic send_blk(input logic [BW-1:0] b, input logic m);
        int w = 0;
        blk_in = b;
        blk_mode = m;
        blk_valid = 1'b1;
        while (!blk_ready && w < 200) begin tick(); w++; end
        check_eq("blk_accept", blk_ready, 1'b1);
        tick();
        blk_valid = 1'b0;
        exp_q.push_back({m, simon_model(cur_key, b, m)});
    endtask

    task automatic recv(input int stall, input string tag);
        int w = 0;
        int bad = 0;
        int h0;
        logic [BW:0]   e;
        logic [BW-1:0] d0;
        logic          m0;
        while (!res_valid && w < 300) begin tick(); w++; end
        check_eq({tag, "_valid"}, res_valid, 1'b1);
        check_eq({tag, "_expect"}, exp_q.size(), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        d0 = res_data;
        m0 = res_mode;
        repeat (stall) begin
            tick();
            if (!res_valid || res_data !== d0 || res_mode !== m0 || blk_ready || newData) bad++;
        end
        check_eq({tag, "_hold"}, bad, 0);
        check_eq({tag, "_data"}, res_data, e[BW-1:0]);
        check_eq({tag, "_mode"}, res_mode, e[BW]);
        last_data = res_data;
        last_mode = res_mode;
        h0 = res_hs;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq({tag, "_hs"}, res_hs - h0, 1);
        check_eq({tag, "_drop"}, res_valid, 1'b0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int n;
        int w;
        logic [BW-1:0] b;
        logic          m;

        repeat (3) tick();
        check_eq("rst_flags", {key_ready, blk_ready, res_valid, err}, 4'h0);
        check_eq("rst_req", {newKey, newData, enc_dec, readData}, 4'h0);
        check_eq("rst_key", key, '0);
        check_eq("rst_plain", plain, '0);
        check_eq("rst_res", {res_mode, res_data}, '0);
        nR = 1'b1;
        tick();
        check_eq("idle_key_ready", key_ready, 1'b1);

        // No key loaded: an offered block must be refused.
        blk_in = KAT_PT; blk_mode = 1'b1; blk_valid = 1'b1;
        n = 0;
        repeat (20) begin tick(); if (blk_ready) n++; end
        check_eq("nokey_blk_ready", n, 0);

        fork
            send_key(KAT_KEY);
            send_blk(KAT_PT, 1'b1);
        join
        check_eq("key_before_done", key_hs_cyc < donekey_cyc, 1'b1);
        check_eq("blk_after_done", blk_hs_cyc > donekey_cyc, 1'b1);
        recv(0, "kat_enc");
        check_eq("kat_enc_value", last_data, KAT_CT);
        check_eq("kat_enc_mode", last_mode, 1'b1);

        send_blk(KAT_CT, 1'b0);
        recv(2, "kat_dec");
        check_eq("kat_dec_value", last_data, KAT_PT);
        check_eq("kat_dec_mode", last_mode, 1'b0);

        // Downstream stall with another block pending.
        send_blk(KAT_PT, 1'b1);
        blk_in = KAT_CT; blk_mode = 1'b0; blk_valid = 1'b1;
        recv(50, "stall");
        send_blk(KAT_CT, 1'b0);
        recv(1, "after_stall");

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0)
                send_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            b = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            send_blk(b, m);
            recv(int'($urandom_range(0, 6)), "rnd");
        end

        // Watchdog: core never acknowledges newData.
        stub_no_ack = 1'b1;
        send_blk(KAT_PT, 1'b1);
        exp_q.delete();
        n = 0;
        while (newData && n < 100) begin n++; tick(); end
        check_eq("to_newdata_len", n, TO);
        check_eq("to_err", err, 1'b1);
        check_eq("to_outs", {newData, key_ready, blk_ready}, 3'b000);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_eq("clr_err", err, 1'b0);
        check_eq("clr_key_ready", key_ready, 1'b1);
        blk_valid = 1'b1;
        n = 0;
        repeat (10) begin tick(); if (blk_ready) n++; end
        blk_valid = 1'b0;
        check_eq("clr_need_key", n, 0);

        // err_clr landing on the timeout cycle must not clear err.
        send_key(KAT_KEY);
        send_blk(KAT_PT, 1'b0);
        exp_q.delete();
        repeat (TO - 1) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_eq("to_clr_same_err", err, 1'b1);
        check_eq("to_clr_same_nd", newData, 1'b0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        stub_no_ack = 1'b0;

        // Reset while the core is running.
        send_key(KAT_KEY);
        stub_run_dly = 12;
        send_blk(KAT_PT, 1'b1);
        w = 0;
        while (cs != 7 && w < 100) begin tick(); w++; end
        check_eq("reach_run", cs, 7);
        tick(); tick();
        @(negedge clk);
        nR = 1'b0;
        #1;
        check_eq("mid_rst_req", {newKey, newData, readData, enc_dec}, 4'h0);
        check_eq("mid_rst_flags", {res_valid, key_ready, blk_ready, err}, 4'h0);
        check_eq("mid_rst_plain", plain, '0);
        check_eq("mid_rst_key", key, '0);
        @(negedge clk);
        nR = 1'b1;
        stub_run_dly = -1;
        exp_q.delete();
        n = 0;
        repeat (40) begin tick(); if (res_valid) n++; end
        check_eq("mid_rst_no_res", n, 0);
        blk_valid = 1'b1;
        n = 0;
        repeat (10) begin tick(); if (blk_ready) n++; end
        blk_valid = 1'b0;
        check_eq("mid_rst_unloaded", n, 0);
        check_eq("mid_rst_key_ready", key_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "bench time limit");
    end
endmodule
